// File: rtl/mix_pkg.sv
// Shared types and width helpers for the pipelined mix datapath.
package mix_pkg;

   // Per-beat operation selected on the input side.
   typedef enum logic [1:0] {
      MODE_PASS    = 2'd0,
      MODE_XOR     = 2'd1,
      MODE_ACC_ADD = 2'd2,
      MODE_ACC_SUB = 2'd3
   } mode_e;

   // Width of the masked subtract/shift mix term.
   function automatic int t0_w(input int in_w);
      return in_w + 1;
   endfunction

   // Width of the full, untruncated product t0 * (x + 1).
   function automatic int p_w(input int in_w);
      return 2 * in_w + 2;
   endfunction

endpackage

// File: rtl/pipelined_mix_datapath_if.sv
// Operand/result handshake bundle. The master side is the operand source and
// result consumer; the slave side is the datapath.
interface pipelined_mix_datapath_if
   import mix_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 37
);
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   in_data;
   mode_e             in_mode;
   logic              acc_clr;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  out_data;

   modport master (
      output in_valid, in_data, in_mode, acc_clr, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, acc_clr, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/mix_t0_unit.sv
// Stage-1 mix term: t0 = (((x - ~x) << x) >> x) | x, all in IN_W+1 bits.
// A shift amount at or beyond the term width clears the shifted value.
module mix_t0_unit
   import mix_pkg::*;
#(
   parameter int IN_W = 4
)
(
   input  logic [IN_W-1:0]        x,
   output logic [t0_w(IN_W)-1:0]  t0
);
   localparam int T0_W = t0_w(IN_W);

   logic [T0_W-1:0] x_ext;
   logic [T0_W-1:0] nx_ext;
   logic [T0_W-1:0] d;
   logic [T0_W-1:0] d_shl;
   logic [T0_W-1:0] u;

   // Subtract, then shift left and back right so high bits fall off the top.
   always_comb begin
      x_ext  = {1'b0, x};
      nx_ext = {1'b0, ~x};
      d      = x_ext - nx_ext;
      d_shl  = d << x;
      u      = d_shl >> x;
      t0     = u | x_ext;
   end
endmodule

// File: rtl/pipelined_mix_datapath.sv
// Three-stage mix datapath: operand capture / t0, product, mode-dependent
// result with an accumulator. One global advance moves every stage together.
module pipelined_mix_datapath
   import mix_pkg::*;
#(
   parameter int IN_W  = 4,
   parameter int OUT_W = 37
)
(
   input logic                     clk,
   input logic                     rst_n,
   pipelined_mix_datapath_if.slave bus
);
   localparam int T0_W = t0_w(IN_W);
   localparam int P_W  = p_w(IN_W);

   logic              en;

   logic              s1_valid;
   logic [IN_W-1:0]   s1_x;
   mode_e             s1_mode;

   logic              s2_valid;
   logic [IN_W-1:0]   s2_x;
   logic [T0_W-1:0]   s2_t0;
   mode_e             s2_mode;

   logic              s3_valid;
   logic [P_W-1:0]    s3_p;
   logic [T0_W-1:0]   s3_t0;
   mode_e             s3_mode;

   logic [T0_W-1:0]   t0_comb;
   logic [IN_W:0]     x_inc;
   logic [P_W-1:0]    p_comb;

   logic [OUT_W-1:0]  acc;
   logic [OUT_W-1:0]  acc_base;
   logic [OUT_W-1:0]  acc_next;
   logic [OUT_W-1:0]  result;
   logic              acc_move;

   logic              out_valid_q;
   logic [OUT_W-1:0]  out_data_q;

   // Whole pipe advances unless a held result is waiting on the consumer.
   assign en            = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = en;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

   mix_t0_unit #(.IN_W(IN_W)) u_t0 (
      .x  (s1_x),
      .t0 (t0_comb)
   );

   // Stage-2 product, kept at full width so nothing is truncated.
   always_comb begin
      x_inc  = {1'b0, s2_x} + (IN_W+1)'(1);
      p_comb = P_W'(s2_t0) * P_W'(x_inc);
   end

   // Stage-3 result select; a clear coincident with an ACC beat applies first.
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      acc_base = bus.acc_clr ? '0 : acc;
      acc_next = acc_base;
      result   = OUT_W'(s3_p);
      acc_move = en && s3_valid &&
                 (s3_mode == MODE_ACC_ADD || s3_mode == MODE_ACC_SUB);
      case (s3_mode)
         MODE_PASS: result = OUT_W'(s3_p);
         MODE_XOR:  result = OUT_W'(s3_p ^ P_W'(s3_t0));
         MODE_ACC_ADD: begin
            acc_next = acc_base + OUT_W'(s3_p);
            result   = acc_next;
         end
         MODE_ACC_SUB: begin
            acc_next = acc_base - OUT_W'(s3_p);
            result   = acc_next;
         end
         default: result = OUT_W'(s3_p);
      endcase
   end

   // Stage registers; bubbles travel with the data and are never collapsed.
   // NOTE: state uses non-blocking assignments so every stage samples the
   // pre-edge value of its predecessor.
   // NOTE: data registers are reset too, so out_data and the stage contents
   // are defined right after reset rather than left as unknowns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_mode  <= MODE_PASS;
         s2_valid <= 1'b0;
         s2_x     <= '0;
         s2_t0    <= '0;
         s2_mode  <= MODE_PASS;
         s3_valid <= 1'b0;
         s3_p     <= '0;
         s3_t0    <= '0;
         s3_mode  <= MODE_PASS;
      end else if (en) begin
         s1_valid <= bus.in_valid;
         s1_x     <= bus.in_data;
         s1_mode  <= bus.in_mode;
         s2_valid <= s1_valid;
         s2_x     <= s1_x;
         s2_t0    <= t0_comb;
         s2_mode  <= s1_mode;
         s3_valid <= s2_valid;
         s3_p     <= p_comb;
         s3_t0    <= s2_t0;
         s3_mode  <= s2_mode;
      end
   end

   // Output register: loads on advance, holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (en) begin
         out_valid_q <= s3_valid;
         if (s3_valid) begin
            out_data_q <= result;
         end
      end
   end

   // Accumulator: moves only with an ACC beat leaving stage 3, else a lone clear zeroes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (acc_move) begin
         acc <= acc_next;
      end else if (bus.acc_clr) begin
         acc <= '0;
      end
   end
endmodule

// File: doc/pipelined_mix_datapath.md
Name: pipelined_mix_datapath

Overview:
- Parametrised, pipelined successor to the team's single-shot combinational mix datapath.
- Takes an IN_W-bit operand and computes a masked subtract/shift mix term (t0), then a product term (p).
- A per-beat mode selects pass, xor-fold, accumulate or de-accumulate into an OUT_W-bit accumulator.
- Valid/ready on both sides; sits between an operand source and a result consumer that may stall.

Parameters:
- IN_W, 4, operand width (>=2).
- OUT_W, 37, result/accumulator width (>= 2*IN_W+2).
- T0_W, IN_W+1, mix-term width (derived, not overridable).
- P_W, 2*IN_W+2, product width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_data  in  IN_W  operand x.
- in_mode  in  2  0=PASS, 1=XOR, 2=ACC_ADD, 3=ACC_SUB.
- acc_clr  in  1  synchronous accumulator clear request.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  OUT_W  result.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_data 0, accumulator 0, in_ready 1.
- Global advance en = !out_valid || out_ready. in_ready = en. A beat transfers when in_valid && in_ready.
- Pipeline bubbles are not collapsed. Every stage moves only on en.
- Latency 3: a beat accepted at edge N is presented on out_data after edge N+3 when there is no stall.
- Stage 1 captures x and mode.
- Stage 1 computes t0 (T0_W bits, all arithmetic modulo 2^T0_W):
  - d = {0,x} - {0,~x}.
  - u = (d << x) >> x, with the shift performed in T0_W bits; a shift amount >= T0_W yields 0.
  - t0 = u | {0,x}.
- Stage 2 computes p = t0 * (x+1), unsigned, in P_W bits with no truncation.
- Stage 3 result, depending on mode:
  - PASS: zero-extend(p).
  - XOR: zero-extend(p ^ {0,t0}).
  - ACC_ADD: acc_next = acc + p, mod 2^OUT_W.
  - ACC_SUB: acc_next = acc - p, mod 2^OUT_W.
  - In both ACC modes out_data = acc_next.
- The accumulator updates only when an ACC beat moves from stage 3 into the output register (en && stage3 valid). A stall freezes it.
- acc_clr handling:
  - With no ACC beat moving that cycle, acc becomes 0 at the next edge.
  - Coincident with an ACC beat moving, clear applies first: acc_next = 0 ± p.
  - acc_clr is ignored while reset is asserted.
  - acc_clr never alters out_data already held.
- While out_valid && !out_ready: out_data, out_valid and all stage registers hold; in_ready = 0.
- Reset mid-operation discards all in-flight beats and clears acc. No partial output is ever produced.
- Non-ACC beats leave acc unchanged.

Decomposition:
- Shared package mix_pkg holds:
  - mode_e enum (MODE_PASS, MODE_XOR, MODE_ACC_ADD, MODE_ACC_SUB).
  - localparam functions t0_w(IN_W) and p_w(IN_W).
- One combinational sub-module, mix_t0_unit (in x, out t0), implements the stage-1 function so the bench can reuse it in its reference model.
- Pipeline, handshake and accumulator stay in the top module.

Test Plan:
- PASS corner operands, out_ready=1:
  - x=3 -> t0=3, p=12, out_data=12.
  - x=0 -> t0=17, p=17, out_data=17.
  - x=15 -> t0=15, p=240, out_data=240.
  - Each result appears exactly 3 cycles after acceptance.
- XOR: x=3 mode1 -> out_data=15.
- ACC_ADD / ACC_SUB sequence:
  - x=3 mode2 -> 12.
  - x=3 mode2 -> 24.
  - x=15 mode3 -> 2^37-216 = 137438953256 (wrap).
- Clear:
  - acc_clr alone -> next ACC_ADD x=3 yields 12.
  - acc_clr coincident with ACC_ADD x=3 moving out of stage 3 -> out_data=12, not acc+12.
- Backpressure:
  - Stream 5 beats with out_ready low for 4 cycles mid-stream -> in_ready drops while out_valid is high and unaccepted.
  - No beat is lost or duplicated, order is preserved, and acc matches the model.
- Reset mid-stream with 3 beats in flight -> out_valid=0, out_data=0, acc=0 immediately on rst_n low.
  - The first post-reset ACC_ADD x=3 yields 12.
